// File: rtl/sine_pkg.sv
// Shared constants and helpers for the quarter-wave sine sequencer.
// Table geometry, BRAM timing, quadrant codes and FSM states live here.
package sine_pkg;

    localparam int ADDR_W      = 6;
    localparam int BRAM_ADDR_W = 8;
    localparam int DATA_W      = 11;
    localparam int BRAM_LAT    = 2;
    localparam int DIV_W       = 16;
    localparam int DIV_DEFAULT = 1493;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quad_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Odd quadrants walk the quarter table backwards (63 - offset).
    function automatic logic [ADDR_W-1:0] fold_addr(
        input logic [ADDR_W+1:0] ph
    );
        logic [ADDR_W-1:0] off;
        off = ph[ADDR_W-1:0];
        case (quad_t'(ph[ADDR_W+1:ADDR_W]))
            Q1, Q3:  fold_addr = ~off;
            default: fold_addr = off;
        endcase
    endfunction

    // The second half-wave is negative.
    function automatic logic is_neg(input logic [ADDR_W+1:0] ph);
        case (quad_t'(ph[ADDR_W+1:ADDR_W]))
            Q2, Q3:  is_neg = 1'b1;
            default: is_neg = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sample_tick_div.sv
// Loadable sample-period divider with synchronous clear and hold.
// The entry cycle counts as count 0 of the first period.
module sample_tick_div
    import sine_pkg::*;
#(
    parameter int W          = DIV_W,
    parameter int RST_PERIOD = DIV_DEFAULT
) (
    input  logic         CLK100MHZ,
    input  logic         rst,
    input  logic         run,
    input  logic         start,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic         tick
);

    logic [W-1:0] cnt;
    logic [W-1:0] per;
    logic [W-1:0] div_eff;
    logic [W-1:0] per_eff;
    logic [W-1:0] cnt_eff;

    assign div_eff = (div == '0) ? W'(1) : div;
    assign per_eff = start ? div_eff : per;
    assign cnt_eff = start ? '0 : cnt;
    assign tick    = run && (cnt_eff == per_eff - W'(1));

    // Count while running; reload the period at each wrap; clear wins.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            per <= W'(RST_PERIOD);
        end else begin
            if (run) begin
                if (tick) begin
                    cnt <= '0;
                    per <= div_eff;
                end else begin
                    cnt <= cnt_eff + W'(1);
                    per <= per_eff;
                end
            end
            if (clr) begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sine_lut_sequencer.sv
// Phase accumulator and read master for the quarter-wave sine BRAM.
// Folds phase into a table address and re-signs the returned magnitude.
module sine_lut_sequencer
    import sine_pkg::*;
(
    input  logic                   CLK100MHZ,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   phase_clr,
    input  logic [DIV_W-1:0]       div,
    input  logic [ADDR_W+1:0]      step,
    output logic                   bram_ena,
    output logic                   bram_wea,
    output logic [BRAM_ADDR_W-1:0] bram_addra,
    input  logic [DATA_W-1:0]      bram_douta,
    output logic signed [DATA_W:0] sample,
    output logic                   sample_valid,
    output logic [1:0]             quadrant
);

    state_t                 state;
    logic [ADDR_W+1:0]      phase;
    logic [ADDR_W+1:0]      rd_phase;
    logic                   tick;
    logic                   start;
    logic [BRAM_LAT:0]      pv;
    logic [BRAM_LAT:0]      ps;
    logic signed [DATA_W:0] mag;

    assign start    = enable && (state == IDLE);
    assign rd_phase = phase_clr ? '0 : phase;
    assign mag      = {1'b0, bram_douta};
    assign bram_wea = 1'b0;

    sample_tick_div #(
        .W          (DIV_W),
        .RST_PERIOD (DIV_DEFAULT)
    ) u_div (
        .CLK100MHZ (CLK100MHZ),
        .rst       (rst),
        .run       (enable),
        .start     (start),
        .clr       (phase_clr),
        .div       (div),
        .tick      (tick)
    );

    // Run/stop FSM; the BRAM is enabled only while running.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            bram_ena <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (enable) begin
                    state    <= RUN;
                    bram_ena <= 1'b1;
                end
                RUN: if (!enable) begin
                    state    <= IDLE;
                    bram_ena <= 1'b0;
                end
            endcase
        end
    end

    // Issue one read per tick and advance the phase accumulator.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            phase      <= '0;
            bram_addra <= '0;
            quadrant   <= '0;
        end else if (tick) begin
            bram_addra <= BRAM_ADDR_W'(fold_addr(rd_phase));
            quadrant   <= rd_phase[ADDR_W+1:ADDR_W];
            phase      <= rd_phase + step;
        end else if (phase_clr) begin
            phase <= '0;
        end
    end

    // Carry valid and sign alongside the BRAM latency, then re-sign.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            pv           <= '0;
            ps           <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
        end else begin
            pv           <= {pv[BRAM_LAT-1:0], tick};
            ps           <= {ps[BRAM_LAT-1:0], is_neg(rd_phase)};
            sample_valid <= pv[BRAM_LAT];
            if (pv[BRAM_LAT]) begin
                sample <= ps[BRAM_LAT] ? -mag : mag;
            end
        end
    end

endmodule

// File: tb/tb_sine_lut_sequencer.sv
// Directed bench for sine_lut_sequencer with a behavioural reference model.
// A BRAM model returns mag[a] = a*32 two clocks after the address.
module tb_sine_lut_sequencer;

    logic               CLK100MHZ = 1'b0;
    logic               rst;
    logic               enable;
    logic               phase_clr;
    logic [15:0]        div;
    logic [7:0]         step;
    logic               bram_ena;
    logic               bram_wea;
    logic [7:0]         bram_addra;
    logic [10:0]        bram_douta;
    logic signed [11:0] sample;
    logic               sample_valid;
    logic [1:0]         quadrant;

    int checks = 0;
    int errors = 0;

    always #5 CLK100MHZ = ~CLK100MHZ;

    sine_lut_sequencer dut (
        .CLK100MHZ    (CLK100MHZ),
        .rst          (rst),
        .enable       (enable),
        .phase_clr    (phase_clr),
        .div          (div),
        .step         (step),
        .bram_ena     (bram_ena),
        .bram_wea     (bram_wea),
        .bram_addra   (bram_addra),
        .bram_douta   (bram_douta),
        .sample       (sample),
        .sample_valid (sample_valid),
        .quadrant     (quadrant)
    );

    // Two-clock BRAM: address registered, then output register.
    logic [10:0] bram_r1;
    always @(posedge CLK100MHZ) begin
        bram_r1    <= {bram_addra[5:0], 5'd0};
        bram_douta <= bram_r1;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        if (i < q.size()) return q[i];
        return -99999;
    endfunction

    // Reference model state (updated once per clock at the falling edge).
    int m_phase, m_cnt, m_per, m_addr, m_quad, m_sample;
    bit m_run, m_ena, m_issued, exp_sv;
    bit pend_v[4];
    int pend_val[4];
    int cyc = 0;
    bit logging = 0;
    int sv_cyc[$];
    int addr_log[$];
    int samp_log[$];

    always @(negedge CLK100MHZ) begin
        int p, off, slot;
        cyc++;
        exp_sv   = 0;
        m_issued = 0;
        if (rst) begin
            m_phase  = 0;
            m_cnt    = 0;
            m_per    = 1493;
            m_run    = 0;
            m_ena    = 0;
            m_addr   = 0;
            m_quad   = 0;
            m_sample = 0;
            for (int i = 0; i < 4; i++) pend_v[i] = 0;
        end else begin
            slot = cyc % 4;
            if (pend_v[slot]) begin
                exp_sv       = 1;
                m_sample     = pend_val[slot];
                pend_v[slot] = 0;
            end
            if (enable) begin
                if (!m_run) begin
                    m_per = (div == 0) ? 1 : int'(div);
                    m_cnt = 0;
                end
                if (m_cnt == m_per - 1) begin
                    p      = phase_clr ? 0 : m_phase;
                    off    = p % 64;
                    m_quad = p / 64;
                    m_addr = (m_quad % 2 == 1) ? 63 - off : off;
                    pend_v[(cyc + 3) % 4]   = 1;
                    pend_val[(cyc + 3) % 4] =
                        (m_quad >= 2) ? -(m_addr * 32) : m_addr * 32;
                    m_phase  = (p + int'(step)) % 256;
                    m_per    = (div == 0) ? 1 : int'(div);
                    m_cnt    = 0;
                    m_issued = 1;
                end else begin
                    m_cnt++;
                end
            end
            if (phase_clr) begin
                m_cnt = 0;
                if (!m_issued) m_phase = 0;
            end
            m_run = enable;
            m_ena = enable;
        end
        chk("bram_ena", int'(bram_ena), int'(m_ena));
        chk("bram_wea", int'(bram_wea), 0);
        chk("bram_addra", int'(bram_addra), m_addr);
        chk("quadrant", int'(quadrant), m_quad);
        chk("sample_valid", int'(sample_valid), int'(exp_sv));
        chk("sample", int'(sample), m_sample);
        if (sample_valid) begin
            sv_cyc.push_back(cyc);
            if (logging) samp_log.push_back(int'(sample));
        end
        if (logging) addr_log.push_back(int'(bram_addra));
    end

    task automatic step_cycles(input int n);
        repeat (n) @(negedge CLK100MHZ);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g, bad, t0, n, ena_hi, e;
        rst       = 1;
        enable    = 0;
        phase_clr = 0;
        div       = 16'd1493;
        step      = 8'd0;
        step_cycles(3);
        rst = 0;
        step_cycles(2);
        chk("reset_sample", int'(sample), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_addra", int'(bram_addra), 0);
        chk("reset_ena", int'(bram_ena), 0);

        // Quadrant fold: one read per clock over a full turn.
        div       = 16'd1;
        step      = 8'd1;
        phase_clr = 1;
        step_cycles(1);
        phase_clr = 0;
        addr_log.delete();
        samp_log.delete();
        logging = 1;
        enable  = 1;
        step_cycles(256);
        enable = 0;
        step_cycles(4);
        logging = 0;
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            int ex;
            ex = ((k / 64) % 2 == 1) ? 63 - (k % 64) : k % 64;
            if (qget(addr_log, k) != ex) bad++;
        end
        chk("fold_seq_bad", bad, 0);
        chk("fold_addr_63", qget(addr_log, 63), 63);
        chk("fold_addr_64", qget(addr_log, 64), 63);
        chk("fold_addr_127", qget(addr_log, 127), 0);
        chk("fold_addr_191", qget(addr_log, 191), 63);
        chk("fold_nsamp", samp_log.size(), 256);
        chk("samp_ph63", qget(samp_log, 63), 2016);
        chk("samp_ph64", qget(samp_log, 64), 2016);
        chk("samp_ph128", qget(samp_log, 128), 0);
        chk("samp_ph130", qget(samp_log, 130), -64);
        chk("samp_ph192", qget(samp_log, 192), -2016);
        chk("samp_ph255", qget(samp_log, 255), 0);

        // Enable drop one cycle after a tick.
        div    = 16'd3;
        step   = 8'd5;
        enable = 1;
        g = 0;
        do begin
            step_cycles(1);
            g++;
        end while (!m_issued && g < 20);
        chk("drop_tick_seen", int'(m_issued), 1);
        enable = 0;
        t0     = cyc;
        ena_hi = 0;
        for (int k = 0; k < 12; k++) begin
            step_cycles(1);
            if (bram_ena) ena_hi++;
        end
        n = 0;
        e = -1;
        foreach (sv_cyc[i]) begin
            if (sv_cyc[i] > t0) begin
                n++;
                e = sv_cyc[i] - t0;
            end
        end
        chk("drop_strobes", n, 1);
        chk("drop_strobe_delay", e, 3);
        chk("drop_ena_high", ena_hi, 0);

        // Divider timing at the default period.
        div  = 16'd1493;
        step = 8'd16;
        step_cycles(2);
        sv_cyc.delete();
        e      = cyc;
        enable = 1;
        g = 0;
        while (sv_cyc.size() < 2 && g < 3200) begin
            step_cycles(1);
            g++;
        end
        chk("div_wait", int'(sv_cyc.size() >= 2), 1);
        chk("div_first_strobe", qget(sv_cyc, 0) - (e + 1), 1495);
        chk("div_gap", qget(sv_cyc, 1) - qget(sv_cyc, 0), 1493);
        enable = 0;
        step_cycles(6);

        // Mid-period divider change takes effect next period.
        div  = 16'd10;
        step = 8'd4;
        step_cycles(2);
        sv_cyc.delete();
        enable = 1;
        g = 0;
        while (sv_cyc.size() < 1 && g < 40) begin
            step_cycles(1);
            g++;
        end
        g = 0;
        while (m_cnt != 5 && g < 20) begin
            step_cycles(1);
            g++;
        end
        chk("chg_at_count5", m_cnt, 5);
        div = 16'd4;
        g = 0;
        while (sv_cyc.size() < 4 && g < 60) begin
            step_cycles(1);
            g++;
        end
        chk("chg_gap0", qget(sv_cyc, 1) - qget(sv_cyc, 0), 10);
        chk("chg_gap1", qget(sv_cyc, 2) - qget(sv_cyc, 1), 4);
        chk("chg_gap2", qget(sv_cyc, 3) - qget(sv_cyc, 2), 4);
        enable = 0;
        step_cycles(6);

        // phase_clr coincident with the tick that would read phase 200.
        div       = 16'd4;
        step      = 8'd8;
        phase_clr = 1;
        step_cycles(1);
        phase_clr = 0;
        enable    = 1;
        g = 0;
        do begin
            step_cycles(1);
            g++;
        end while (!(m_run && m_phase == 200 && m_cnt == m_per - 1)
                   && g < 300);
        chk("clr_phase200", m_phase, 200);
        phase_clr = 1;
        step_cycles(1);
        phase_clr = 0;
        chk("clr_addr", int'(bram_addra), 0);
        chk("clr_quad", int'(quadrant), 0);
        step_cycles(3);
        chk("clr_valid", int'(sample_valid), 1);
        chk("clr_sample", int'(sample), 0);
        step_cycles(1);
        chk("clr_next_addr", int'(bram_addra), 8);

        // Asynchronous reset mid-run.
        div  = 16'd1;
        step = 8'd3;
        step_cycles(10);
        rst    = 1;
        enable = 0;
        #1;
        chk("arst_sample", int'(sample), 0);
        chk("arst_valid", int'(sample_valid), 0);
        chk("arst_addra", int'(bram_addra), 0);
        chk("arst_ena", int'(bram_ena), 0);
        chk("arst_quad", int'(quadrant), 0);
        step_cycles(2);
        rst = 0;
        sv_cyc.delete();
        step_cycles(10);
        chk("arst_no_strobe", sv_cyc.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
